// File: rtl/mha_acc_drain_if.sv
// Valid/ready bundle for mha_acc_drain: staged partial-sum input stream and requantized output stream.
interface mha_acc_drain_if #(
    parameter int unsigned acc_width       = 19,
    parameter int unsigned systolic_column = 16,
    parameter int unsigned pe_blk_count    = 16,
    parameter int unsigned out_width       = 8,
    parameter int unsigned shift_width     = 5
);
    localparam int unsigned in_bits   = acc_width * systolic_column * pe_blk_count;
    localparam int unsigned out_bits  = out_width * systolic_column;
    localparam int unsigned blk_width = (pe_blk_count > 1) ? $clog2(pe_blk_count) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_first;
    logic                   in_last;
    logic [in_bits-1:0]     acc_in;
    logic [shift_width-1:0] shift_amt;
    logic                   out_valid;
    logic                   out_ready;
    logic [out_bits-1:0]    out_data;
    logic [blk_width-1:0]   out_blk_idx;
    logic                   out_last;

    modport master (
        output in_valid, in_first, in_last, acc_in, shift_amt, out_ready,
        input  in_ready, out_valid, out_data, out_blk_idx, out_last
    );

    modport slave (
        input  in_valid, in_first, in_last, acc_in, shift_amt, out_ready,
        output in_ready, out_valid, out_data, out_blk_idx, out_last
    );
endinterface

// File: rtl/mha_acc_drain.sv
// Accumulates K-tile partial sums from the PE array, then requantizes and streams one PE block per beat.
// Define ACC_DRAIN_RELU_EN to clamp negative requantized lanes to zero before output saturation.
module mha_acc_drain #(
    parameter int unsigned acc_width       = 19,
    parameter int unsigned systolic_column = 16,
    parameter int unsigned pe_blk_count    = 16,
    parameter int unsigned sum_width       = 32,
    parameter int unsigned out_width       = 8,
    parameter int unsigned shift_width     = 5
) (
    input logic            clk,
    input logic            reset,
    mha_acc_drain_if.slave bus
);
    localparam int unsigned lanes      = systolic_column * pe_blk_count;
    localparam int unsigned lane_width = (lanes > 1) ? $clog2(lanes) : 1;
    localparam int unsigned blk_width  = (pe_blk_count > 1) ? $clog2(pe_blk_count) : 1;

    localparam logic [blk_width-1:0]        last_blk = blk_width'(pe_blk_count - 1);
    localparam logic signed [sum_width-1:0] sum_max  = {1'b0, {(sum_width-1){1'b1}}};
    localparam logic signed [sum_width-1:0] sum_min  = {1'b1, {(sum_width-1){1'b0}}};
    localparam logic signed [sum_width:0]   out_max  = (sum_width+1)'((2 ** (out_width-1)) - 1);
    localparam logic signed [sum_width:0]   out_min  = -((sum_width+1)'(2 ** (out_width-1)));

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                      state;
    logic signed [sum_width-1:0] sums       [lanes];
    logic signed [sum_width-1:0] next_sum_c [lanes];
    logic [shift_width-1:0]      shift_q;
    logic [blk_width-1:0]        blk;

    // Saturating add of one accumulator lane into a running sum.
    function automatic logic signed [sum_width-1:0] sat_add(
        input logic signed [sum_width-1:0] a,
        input logic signed [acc_width-1:0] b
    );
        logic signed [sum_width:0] t;
        t = (sum_width+1)'(a) + (sum_width+1)'(b);
        if (t[sum_width] != t[sum_width-1]) begin
            sat_add = t[sum_width] ? sum_min : sum_max;
        end else begin
            sat_add = t[sum_width-1:0];
        end
    endfunction

    // Round half up, arithmetic shift, then clamp into the signed output range.
    function automatic logic [out_width-1:0] requant(
        input logic signed [sum_width-1:0] s,
        input logic [shift_width-1:0]      sh
    );
        logic signed [sum_width:0] rnd;
        logic signed [sum_width:0] r;
        rnd = '0;
        if (sh != '0) begin
            rnd = (sum_width+1)'(1) << (sh - shift_width'(1));
        end
        r = ((sum_width+1)'(s) + rnd) >>> sh;
`ifdef ACC_DRAIN_RELU_EN
        if (r[sum_width]) begin
            r = '0;
        end
`endif
        if (r > out_max) begin
            r = out_max;
        end else if (r < out_min) begin
            r = out_min;
        end
        requant = out_width'(r);
    endfunction

    always_comb begin
        for (int i = 0; i < int'(lanes); i++) begin
            next_sum_c[lane_width'(i)] = bus.in_first
                ? sum_width'(signed'(bus.acc_in[acc_width*i +: acc_width]))
                : sat_add(sums[lane_width'(i)], bus.acc_in[acc_width*i +: acc_width]);
        end
    end

    // Output lanes follow the held sums of the block being drained.
    always_comb begin
        bus.out_data = '0;
        for (int c = 0; c < int'(systolic_column); c++) begin
            bus.out_data[out_width*c +: out_width] =
                requant(sums[lane_width'(int'(blk) * int'(systolic_column) + c)], shift_q);
        end
    end

    assign bus.out_blk_idx = blk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ACCUM;
            shift_q       <= '0;
            blk           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            for (int i = 0; i < int'(lanes); i++) begin
                sums[lane_width'(i)] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < int'(lanes); i++) begin
                            sums[lane_width'(i)] <= next_sum_c[lane_width'(i)];
                        end
                        if (bus.in_last) begin
                            shift_q       <= bus.shift_amt;
                            blk           <= '0;
                            state         <= DRAIN;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_last  <= (pe_blk_count == 1);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (blk == last_blk) begin
                            state         <= ACCUM;
                            blk           <= '0;
                            bus.in_ready  <= 1'b1;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                        end else begin
                            blk          <= blk + blk_width'(1);
                            bus.out_last <= ((blk + blk_width'(1)) == last_blk);
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
